// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e        : 3-bit frame FSM state encoding
//   - UART_DATA_W         : payload bits per frame (8)
//   - UART_CYCLES_PER_BIT : default clock cycles per serial bit (217)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_DATA_W         = 8;
  localparam int unsigned UART_CYCLES_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// In-order byte FIFO that buffers bytes ahead of the UART shifter.
// Pointers wrap modulo c_DEPTH (a power of two); occupancy is a registered count.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset (empties FIFO)
//   push      : write wr_data this cycle (ignored while full)
//   wr_data   : byte to store
//   pop       : drop the head entry this cycle (ignored while empty)
//   rd_data   : current head entry
//   full      : count == c_DEPTH
//   empty     : count == 0
//   count     : number of stored bytes, 0..c_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned c_DEPTH = 4,
  localparam int unsigned PTR_W   = $clog2(c_DEPTH),
  localparam int unsigned CNT_W   = $clog2(c_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(c_DEPTH);

  logic [UART_DATA_W-1:0] mem_q [c_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Buffered 8N1 UART transmitter: a byte FIFO feeds a frame FSM and shifter.
// Frame: start bit (0), 8 data bits LSB first, stop bit (1), then one CLEANUP
// cycle and one IDLE cycle, so back-to-back frames repeat every
// 10*c_CYCLES_PER_BIT + 2 cycles.
// Ports:
//   i_CLK            : clock, rising edge
//   i_RST            : synchronous active-high reset (abandons frame, empties FIFO)
//   i_TX_DATA_VALID  : upstream offers i_DATA_TX this cycle
//   i_DATA_TX        : byte to transmit
//   o_TX_READY       : FIFO not full; a byte is taken when valid & ready
//   o_SERIAL_DATA    : registered UART line, idle high
//   o_TX_ACTIVE      : high while start, data or stop bits are on the line
//   o_TX_DONE        : one-cycle pulse at the end of each frame
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned c_CYCLES_PER_BIT = UART_CYCLES_PER_BIT,
  parameter int unsigned c_FIFO_DEPTH     = 4
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_TX_DATA_VALID,
  input  logic [UART_DATA_W-1:0] i_DATA_TX,
  output logic                   o_TX_READY,
  output logic                   o_SERIAL_DATA,
  output logic                   o_TX_ACTIVE,
  output logic                   o_TX_DONE
);

  localparam int unsigned      CNT_W     = $clog2(c_CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(c_CYCLES_PER_BIT - 1);
  localparam int unsigned      FCNT_W    = $clog2(c_FIFO_DEPTH) + 1;
  localparam logic [FCNT_W-1:0] FIFO_CAP = FCNT_W'(c_FIFO_DEPTH);

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCNT_W-1:0]      fifo_count;

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   serial_q, serial_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;

  assign o_TX_READY    = (fifo_count < FIFO_CAP);
  assign fifo_push     = i_TX_DATA_VALID & ~fifo_full;
  assign o_SERIAL_DATA = serial_q;
  assign o_TX_ACTIVE   = active_q;
  assign o_TX_DONE     = done_q;

  uart_tx_fifo #(
    .c_DEPTH (c_FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_CLK),
    .rst     (i_RST),
    .push    (fifo_push),
    .wr_data (i_DATA_TX),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    serial_d  = 1'b1;
    active_d  = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        serial_d = shift_q[0];
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the current state, so the line trails the
  // state register by one cycle; every phase keeps its full length.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx (4 cycles per bit, 4-deep FIFO).
// A frame-level model (byte queue + frame start times) predicts the line,
// active, done and ready outputs every cycle; literal expectations pin the
// model for the 0xA3 frame, back-to-back spacing, full/collision and reset.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int LOGN  = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       line;
  logic       active;
  logic       done;

  uart_tx #(
    .c_CYCLES_PER_BIT (CPB),
    .c_FIFO_DEPTH     (DEPTH)
  ) dut (
    .i_CLK           (clk),
    .i_RST           (rst),
    .i_TX_DATA_VALID (valid),
    .i_DATA_TX       (data),
    .o_TX_READY      (ready),
    .o_SERIAL_DATA   (line),
    .o_TX_ACTIVE     (active),
    .o_TX_DONE       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Frame-level model state
  logic [7:0] m_q[$];
  bit         m_init     = 1'b0;
  bit         m_busy     = 1'b0;
  int         m_pop_edge = 0;
  int         m_next_pop = 0;
  logic [7:0] m_byte     = 8'h00;

  bit line_log [LOGN];
  bit act_log  [LOGN];
  bit done_log [LOGN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Line value k cycles into a frame: slot 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic int li(input int c);
    if (c < 0) return 0;
    if (c >= LOGN) return LOGN - 1;
    return c;
  endfunction

  // Model update at each edge, then compare DUT outputs just after the edge.
  always @(posedge clk) begin
    logic acc;
    logic exp_line, exp_act, exp_done, exp_rdy;
    int   k;
    cyc++;
    if (rst) begin
      m_q.delete();
      m_busy     = 1'b0;
      m_next_pop = cyc + 1;
      m_init     = 1'b1;
    end else if (m_init) begin
      acc = valid && (m_q.size() < DEPTH);
      if (cyc >= m_next_pop && m_q.size() > 0) begin
        m_byte     = m_q.pop_front();
        m_busy     = 1'b1;
        m_pop_edge = cyc;
        m_next_pop = cyc + FRAME + 2;
      end
      if (acc) m_q.push_back(data);
    end
    exp_line = 1'b1;
    exp_act  = 1'b0;
    exp_done = 1'b0;
    if (m_busy) begin
      k = cyc - m_pop_edge - 1;
      if (k >= 0 && k < FRAME) begin
        exp_line = frame_bit(m_byte, k);
        exp_act  = 1'b1;
      end
      exp_done = (cyc == m_pop_edge + 1 + FRAME);
    end
    exp_rdy = (m_q.size() < DEPTH);
    #1;
    line_log[li(cyc)] = line;
    act_log[li(cyc)]  = active;
    done_log[li(cyc)] = done;
    if (m_init) begin
      check("line",   line,   exp_line);
      check("active", active, exp_act);
      check("done",   done,   exp_done);
      check("ready",  ready,  exp_rdy);
    end
  end

  task automatic push_byte(input logic [7:0] b, output int edge_n);
    int guard;
    guard = 0;
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    while (!ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    edge_n = cyc;
  endtask

  task automatic release_valid();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((m_q.size() != 0 || (m_busy && cyc < m_pop_edge + FRAME + 2)) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int e[6];
    int first_low;
    int starts[$];
    int a3_bits[10];
    int sum;
    int g;
    int rst_edge;

    a3_bits = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};

    // Reset with a byte offered: it must not be taken.
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h77;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_ready",  ready,  1);
    check("reset_line",   line,   1);
    check("reset_active", active, 0);

    // Single 0xA3 frame
    push_byte(8'hA3, n);
    release_valid();
    wait_drain();
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < CPB; j++)
        check($sformatf("a3_bit%0d", b), line_log[li(n + 2 + CPB*b + j)], a3_bits[b]);
    check("a3_line_before", line_log[li(n + 1)], 1);
    check("a3_done_at_42", done_log[li(n + 42)], 1);
    sum = 0;
    for (int c = n; c <= n + 50; c++) sum += done_log[li(c)];
    check("a3_done_pulses", sum, 1);

    // Hold valid for 0x01..0x06 continuously
    first_low = 0;
    for (int i = 0; i < 6; i++) begin
      push_byte(8'(i + 1), e[i]);
      if (!ready && first_low == 0) first_low = i + 1;
    end
    release_valid();
    wait_drain();
    check("ready_drop_after_accepts", first_low, 5);
    for (int c = e[0]; c <= cyc; c++)
      if (act_log[li(c)] && !act_log[li(c - 1)]) starts.push_back(c);
    check("b2b_frames", starts.size(), 6);
    if (starts.size() > 0) check("b2b_first_start", starts[0], e[0] + 2);
    for (int i = 1; i < starts.size(); i++)
      check("b2b_period", starts[i] - starts[i-1], 42);

    // Push/pop collision with three bytes buffered
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i), n);
    release_valid();
    g = 0;
    while (cyc < m_next_pop - 1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("collide_count_before", dut.fifo_count, 3);
    valid = 1'b1;
    data  = 8'h35;
    @(posedge clk);
    #1;
    check("collide_count_after", dut.fifo_count, 3);
    release_valid();
    wait_drain();

    // Reset during data bit 3 of 0x5A with two bytes queued
    push_byte(8'h5A, n);
    push_byte(8'h11, e[0]);
    push_byte(8'h22, e[1]);
    release_valid();
    g = 0;
    while (cyc < n + 17 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("rst_mid_active_before", active, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst_edge = cyc;
    check("rst_mid_line",   line,   1);
    check("rst_mid_active", active, 0);
    check("rst_mid_done",   done,   0);
    check("rst_mid_ready",  ready,  1);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    sum = 0;
    for (int c = rst_edge; c <= cyc; c++) sum += act_log[li(c)] + done_log[li(c)];
    check("rst_mid_no_frames", sum, 0);

    // Fill completely, then offer 0xFF while full
    for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i), n);
    data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("full_ready_low", ready, 0);
    end
    release_valid();
    wait_drain();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 149) == 0);
      valid = ($urandom_range(0, 2) != 0);
      data  = 8'($urandom);
    end
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
